// File: rtl/imem_loader_if.sv
// imem_loader_if: UART line in, instruction memory write port and processor reset out.
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic              rxd;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rstd;
  logic              busy;
  logic              done;
  logic              err;
  modport master (output rxd, input im_we, im_addr, im_wdata, cpu_rstd, busy, done, err);
  modport slave  (input rxd, output im_we, im_addr, im_wdata, cpu_rstd, busy, done, err);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: UART 8N1 boot loader writing a checksummed program into instruction memory,
// then releasing the processor reset.
module imem_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 8
) (
  input logic         clk,
  input logic         rstd,
  imem_loader_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [1:0] {FR_WAIT, FR_DATA, FR_CHECK, FR_RUN} fr_t;
  rx_t               r_rx_st, w_rx_nx;
  fr_t               r_fr_st, w_fr_nx;
  logic              r_rx1, r_rxs;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_sh, r_last, r_widx, r_xor;
  logic [1:0]        r_bcnt;
  logic [31:0]       r_word, r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we, r_run, r_busy, r_err;
  logic              w_tick, w_bv, w_ferr, w_last_b;
  // The start bit is checked at its centre, so every later sample lands mid-bit too
  assign w_tick   = r_cnt == CW'(r_rx_st == RX_START ? CLKS_PER_BIT / 2 - 1 : CLKS_PER_BIT - 1);
  assign w_bv     = r_rx_st == RX_STOP && w_tick && r_rxs;
  assign w_ferr   = r_rx_st == RX_STOP && w_tick && !r_rxs && r_fr_st != FR_RUN;
  assign w_last_b = w_bv && r_fr_st == FR_DATA && r_bcnt == 2'd3;
  always_comb begin
    w_rx_nx = r_rx_st;
    case (r_rx_st)
      RX_IDLE:  w_rx_nx = r_rxs ? RX_IDLE : RX_START;
      RX_START: if (w_tick) w_rx_nx = r_rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && r_bit == 3'd7) w_rx_nx = RX_STOP;
      default:  if (w_tick) w_rx_nx = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      r_rx1   <= 1'b1;
      r_rxs   <= 1'b1;
      r_rx_st <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
    end else begin
      r_rx1   <= bus.rxd;
      r_rxs   <= r_rx1;
      r_rx_st <= w_rx_nx;
      r_cnt   <= (r_rx_st == RX_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
      if (r_rx_st == RX_DATA && w_tick) begin
        r_bit <= r_bit + 1'b1;
        r_sh  <= {r_rxs, r_sh[7:1]};
      end
    end
  end
  always_comb begin
    w_fr_nx = r_fr_st;
    case (r_fr_st)
      FR_WAIT:  if (w_bv) w_fr_nx = FR_DATA;
      FR_DATA:  if (w_ferr) w_fr_nx = FR_WAIT;
                else if (w_last_b && r_widx == r_last) w_fr_nx = FR_CHECK;
      FR_CHECK: if (w_ferr) w_fr_nx = FR_WAIT;
                else if (w_bv) w_fr_nx = r_sh == r_xor ? FR_RUN : FR_WAIT;
      default:  w_fr_nx = FR_RUN;
    endcase
  end
  // A COUNT of 0 gives r_last = 255, i.e. a 256-word load
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      r_fr_st <= FR_WAIT;
      r_last  <= '0;
      r_widx  <= '0;
      r_xor   <= '0;
      r_bcnt  <= '0;
      r_word  <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_run   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_fr_st <= w_fr_nx;
      r_we    <= w_last_b;
      if (r_fr_st == FR_WAIT && w_bv) begin
        r_last <= r_sh - 1'b1;
        r_widx <= '0;
        r_bcnt <= '0;
        r_xor  <= '0;
        r_err  <= 1'b0;
        r_busy <= 1'b1;
      end
      if (r_fr_st == FR_DATA && w_bv) begin
        r_word <= {r_sh, r_word[31:8]};
        r_xor  <= r_xor ^ r_sh;
        r_bcnt <= r_bcnt + 1'b1;
      end
      if (w_last_b) begin
        r_wdata <= {r_sh, r_word[31:8]};
        r_addr  <= ADDR_W'(r_widx);
        r_widx  <= r_widx + 1'b1;
      end
      if (w_ferr || (r_fr_st == FR_CHECK && w_bv)) r_busy <= 1'b0;
      if (w_ferr || (r_fr_st == FR_CHECK && w_bv && r_sh != r_xor)) r_err <= 1'b1;
      if (r_fr_st == FR_CHECK && w_bv && r_sh == r_xor) r_run <= 1'b1;
    end
  end
  assign bus.im_we    = r_we;
  assign bus.im_addr  = r_addr;
  assign bus.im_wdata = r_wdata;
  assign bus.cpu_rstd = r_run;
  assign bus.done     = r_run;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized frames against a byte-level load model.
module tb_imem_loader;
  localparam int CPB = 16;
  localparam int AW  = 8;
  typedef logic [7:0] bq_t[$];
  typedef struct {logic [AW-1:0] a; logic [31:0] d;} wr_t;
  typedef struct {bit rst; int len; logic [7:0] b[0:11]; int bad; bit e_err; bit e_done; int e_wr;} vec_t;
  logic clk = 1'b0;
  logic rstd = 1'b0;
  always #5 clk = ~clk;
  imem_loader_if #(.ADDR_W(AW)) bus();
  imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (.clk(clk), .rstd(rstd), .bus(bus));
  int n_checks = 0, n_errors = 0, n_wr = 0;
  wr_t exp_q[$];
  wr_t e;
  bit m_err = 0, m_done = 0, prev_we = 0;
  vec_t tv[9];
  bq_t q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstd && bus.im_we) begin
      n_wr++;
      chk("we_one_cycle", prev_we, 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", bus.im_addr, bus.im_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.im_addr, e.a);
        chk("wr_data", bus.im_wdata, e.d);
      end
    end
    prev_we = rstd && bus.im_we;
  end

  // Expected effect of a (possibly truncated) byte stream on the loader
  task automatic model_frame(input bq_t b, input int bad);
    int n, i;
    logic [31:0] w;
    logic [7:0] x;
    if (m_done || b.size() == 0) return;
    if (bad == 0) begin m_err = 1; return; end
    n = (b[0] == 0) ? 256 : int'(b[0]);
    m_err = 0;
    x = 0;
    for (int wi = 0; wi < n; wi++) begin
      w = 0;
      for (int k = 0; k < 4; k++) begin
        i = 1 + 4 * wi + k;
        if (i >= b.size()) return;
        if (i == bad) begin m_err = 1; return; end
        w = w | (32'(b[i]) << (8 * k));
        x = x ^ b[i];
      end
      exp_q.push_back('{AW'(wi), w});
    end
    i = 1 + 4 * n;
    if (i >= b.size()) return;
    if (i == bad) begin m_err = 1; return; end
    if (b[i] == x) m_done = 1; else m_err = 1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk) bus.rxd = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) bus.rxd = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
    if (stop_ok) begin
      @(negedge clk) bus.rxd = 1'b1;
      repeat (CPB - 1) @(negedge clk);
    end else begin
      @(negedge clk) bus.rxd = 1'b0;
      repeat (CPB * 3 / 4 - 1) @(negedge clk);
      bus.rxd = 1'b1;
      repeat (CPB / 4) @(negedge clk);
    end
    bus.rxd = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic run_frame(input bq_t b, input int bad);
    model_frame(b, bad);
    for (int i = 0; i < b.size(); i++) send_byte(b[i], i != bad);
    repeat (2 * CPB) @(negedge clk);
    chk("missing_writes", exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {bus.im_we, bus.im_addr, bus.im_wdata, bus.cpu_rstd, bus.busy, bus.done, bus.err}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk) rstd = 1'b0;
    #1 chk_zero("reset_outputs");
    repeat (3) @(negedge clk);
    rstd = 1'b1;
    m_err = 0;
    m_done = 0;
    exp_q.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, n, bad;
    logic [7:0] x, bt;
    tv[0] = '{1, 10, '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h44, 8'h00, 8'h00}, -1, 0, 1, 2};
    tv[1] = '{0, 6,  '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 0, 1, 0};
    tv[2] = '{1, 10, '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h45, 8'h00, 8'h00}, -1, 1, 0, 2};
    tv[3] = '{0, 10, '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h44, 8'h00, 8'h00}, -1, 0, 1, 2};
    tv[4] = '{1, 2,  '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1, 0, 0};
    tv[5] = '{0, 6,  '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 0, 1, 1};
    tv[6] = '{1, 7,  '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 6, 1, 0, 1};
    tv[7] = '{0, 1,  '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 0, 0};
    tv[8] = '{0, 6,  '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, -1, 0, 1, 1};
    bus.rxd = 1'b1;
    repeat (3) @(negedge clk);
    rstd = 1'b1;
    repeat (50) @(negedge clk);
    rstd = 1'b0;
    #1 chk_zero("reset_idle");
    repeat (2) @(negedge clk);
    rstd = 1'b1;
    repeat (1000) @(negedge clk);
    chk("idle_no_write", n_wr, 0);
    chk("idle_busy", bus.busy, 0);
    for (int v = 0; v < 9; v++) begin
      if (tv[v].rst) do_reset();
      q.delete();
      for (int i = 0; i < tv[v].len; i++) q.push_back(tv[v].b[i]);
      w0 = n_wr;
      run_frame(q, tv[v].bad);
      chk($sformatf("vec%0d_err", v), bus.err, tv[v].e_err);
      chk($sformatf("vec%0d_done", v), bus.done, tv[v].e_done);
      chk($sformatf("vec%0d_cpu_rstd", v), bus.cpu_rstd, tv[v].e_done);
      chk($sformatf("vec%0d_busy", v), bus.busy, 0);
      chk($sformatf("vec%0d_writes", v), n_wr - w0, tv[v].e_wr);
    end
    do_reset();
    w0 = n_wr;
    @(negedge clk) bus.rxd = 1'b0;
    repeat (5) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_writes", n_wr - w0, 0);
    chk("glitch_busy", bus.busy, 0);
    chk("glitch_err", bus.err, 0);
    q = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    run_frame(q, -1);
    chk("glitch_then_load_done", bus.done, 1);
    do_reset();
    q = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0C};
    model_frame(q[0:6], -1);
    for (int i = 0; i < 6; i++) send_byte(q[i], 1);
    chk("midload_busy", bus.busy, 1);
    fork
      send_byte(q[6], 1);
      begin
        repeat (CPB * 4) @(negedge clk);
        rstd = 1'b0;
        #1 chk_zero("midload_reset_outputs");
      end
    join
    chk("midload_word0_written", exp_q.size(), 0);
    do_reset();
    w0 = n_wr;
    run_frame(q, -1);
    chk("reload_writes", n_wr - w0, 3);
    chk("reload_cpu_rstd", bus.cpu_rstd, 1);
    for (int r = 0; r < 6; r++) begin
      do_reset();
      n = $urandom_range(1, 4);
      q.delete();
      q.push_back(8'(n));
      x = 0;
      repeat (4 * n) begin
        bt = 8'($urandom);
        q.push_back(bt);
        x = x ^ bt;
      end
      q.push_back(($urandom_range(0, 3) != 0) ? x : x ^ 8'($urandom_range(1, 255)));
      bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
      if (bad >= 0) while (q.size() > bad + 1) void'(q.pop_back());
      run_frame(q, bad);
      chk($sformatf("rand%0d_err", r), bus.err, m_err);
      chk($sformatf("rand%0d_done", r), bus.done, m_done);
      chk($sformatf("rand%0d_cpu_rstd", r), bus.cpu_rstd, m_done);
      chk($sformatf("rand%0d_busy", r), bus.busy, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
